// File: rtl/game_round_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the alien reaction game round sequencer:
// the sequencer state encoding, the SPI command byte values, the status
// bytes returned to the MBED and a saturating servo adder.
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_SW,
        HIT,
        MISS,
        GAP,
        DONE,
        MAINT_MODE
    } state_t;

    localparam logic [7:0] CMD_GO    = 8'h01;
    localparam logic [7:0] CMD_MAINT = 8'h02;
    localparam logic [7:0] CMD_ABORT = 8'h04;

    localparam logic [7:0] STAT_IDLE      = 8'd20;
    localparam logic [7:0] STAT_ACK       = 8'd21;
    localparam logic [7:0] STAT_LED_BASE  = 8'd32;
    localparam logic [7:0] STAT_DONE_FLAG = 8'h80;

    // The sum is formed one bit wider so a large step cannot wrap past the
    // limit before the saturation compare sees it.
    function automatic logic [7:0] satAdd(input logic [7:0] base,
                                          input logic [7:0] step,
                                          input logic [7:0] limit);
        logic [8:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        return (sum > {1'b0, limit}) ? limit : sum[7:0];
    endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_round_sequencer_if
// Bundles everything the round sequencer exchanges with its neighbours:
//   cmd_valid/cmd_byte  : byte pulses from the SPI command decoder
//   sw_valid/sw_code    : debounced press pulses from the switch debouncer
//   pat_addr/pat_data   : pattern-table lookup (data is combinational)
//   led_code/led_lit    : target LED drive
//   servo_pos           : servo position
//   spi_status          : status byte returned over SPI
//   score/busy/maint    : game progress and maintenance-mode flag
// master = surrounding top level / bench, slave = the sequencer.
// ---------------------------------------------------------------------------
interface game_round_sequencer_if;

    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       sw_valid;
    logic [2:0] sw_code;
    logic [3:0] pat_addr;
    logic [2:0] pat_data;
    logic [2:0] led_code;
    logic       led_lit;
    logic [7:0] servo_pos;
    logic [7:0] spi_status;
    logic [4:0] score;
    logic       busy;
    logic       maint;

    modport master (
        output cmd_valid, cmd_byte, sw_valid, sw_code, pat_data,
        input  pat_addr, led_code, led_lit, servo_pos, spi_status,
               score, busy, maint
    );

    modport slave (
        input  cmd_valid, cmd_byte, sw_valid, sw_code, pat_data,
        output pat_addr, led_code, led_lit, servo_pos, spi_status,
               score, busy, maint
    );

endinterface

// File: rtl/game_round_sequencer_round_timer.sv
// ---------------------------------------------------------------------------
// round_timer
// Clear/enable down-counter. i_clear reloads COUNT-1; while i_enable is high
// the counter steps down and o_tc pulses on the enabled cycle where it reads
// zero, so an enabled window of exactly COUNT cycles ends on the pulse.
//   clk, rst  : clock, asynchronous active-high reset (reset = reloaded)
//   i_clear   : reload the counter
//   i_enable  : count this cycle
//   o_tc      : terminal-count pulse
// ---------------------------------------------------------------------------
module round_timer #(
    parameter int COUNT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [W-1:0] RELOAD = W'(COUNT - 1);

    logic [W-1:0] r_count;

    // Holds at zero rather than wrapping; the owning state leaves on o_tc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RELOAD;
        end else if (i_clear) begin
            r_count <= RELOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = i_enable && (r_count == '0);

endmodule

// File: rtl/game_round_sequencer.sv
// ---------------------------------------------------------------------------
// game_round_sequencer
// Runs one play session: walks the pattern table, lights each target LED,
// waits for the matching press or a timeout, scores the round, advances the
// servo on hits and publishes a status byte for the SPI return path.
//   clk, rst : 50 MHz clock, asynchronous active-high reset
//   bus      : game_round_sequencer_if.slave (commands, presses, pattern
//              table, LED/servo/status/score/busy/maint outputs)
// ---------------------------------------------------------------------------
module game_round_sequencer #(
    parameter int ROUNDS      = 15,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int GAP_CYC     = 2_500_000,
    parameter int SERVO_STEP  = 5,
    parameter int SERVO_MAX   = 89
) (
    input logic clk,
    input logic rst,
    game_round_sequencer_if.slave bus
);

    import game_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [7:0] STEP8      = 8'(SERVO_STEP);
    localparam logic [7:0] MAX8       = 8'(SERVO_MAX);

    state_t     r_state;
    logic [3:0] r_round;
    logic [2:0] r_ledCode;
    logic       r_ledLit;
    logic [7:0] r_servoPos;
    logic [7:0] r_spiStatus;
    logic [4:0] r_score;
    logic       r_busy;
    logic       r_maint;

    logic w_cmdGo;
    logic w_cmdMaint;
    logic w_cmdAbort;
    logic w_hit;
    logic w_badPress;
    logic w_timeoutClear;
    logic w_timeoutEn;
    logic w_timeoutTc;
    logic w_gapClear;
    logic w_gapEn;
    logic w_gapTc;

    assign w_cmdGo    = bus.cmd_valid && (bus.cmd_byte == CMD_GO);
    assign w_cmdMaint = bus.cmd_valid && (bus.cmd_byte == CMD_MAINT);
    assign w_cmdAbort = bus.cmd_valid && (bus.cmd_byte == CMD_ABORT);
    assign w_hit      = bus.sw_valid && (bus.sw_code == r_ledCode);
    assign w_badPress = bus.sw_valid && (bus.sw_code != r_ledCode);

    // The timeout window is armed during LOAD so WAIT_SW starts at count 0;
    // the gap window is armed by the one-cycle HIT/MISS scoring state.
    assign w_timeoutClear = (r_state == LOAD);
    assign w_timeoutEn    = (r_state == WAIT_SW);
    assign w_gapClear     = (r_state == HIT) || (r_state == MISS);
    assign w_gapEn        = (r_state == GAP);

    round_timer #(.COUNT(TIMEOUT_CYC)) u_timeoutTimer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timeoutClear),
        .i_enable (w_timeoutEn),
        .o_tc     (w_timeoutTc)
    );

    round_timer #(.COUNT(GAP_CYC)) u_gapTimer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_gapClear),
        .i_enable (w_gapEn),
        .o_tc     (w_gapTc)
    );

    // ABORT outranks everything while a game runs; in WAIT_SW a correct
    // press is tested before the timeout so a tie scores as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_ledCode   <= '0;
            r_ledLit    <= 1'b0;
            r_servoPos  <= '0;
            r_spiStatus <= STAT_IDLE;
            r_score     <= '0;
            r_busy      <= 1'b0;
            r_maint     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmdGo) begin
                        r_state     <= LOAD;
                        r_round     <= '0;
                        r_score     <= '0;
                        r_servoPos  <= '0;
                        r_spiStatus <= STAT_ACK;
                        r_busy      <= 1'b1;
                    end else if (w_cmdMaint) begin
                        r_state <= MAINT_MODE;
                        r_maint <= 1'b1;
                    end
                end
                MAINT_MODE: begin
                    if (w_cmdAbort) begin
                        r_state     <= IDLE;
                        r_maint     <= 1'b0;
                        r_spiStatus <= STAT_IDLE;
                    end
                end
                default: begin
                    if (w_cmdAbort) begin
                        r_state     <= IDLE;
                        r_ledLit    <= 1'b0;
                        r_spiStatus <= STAT_IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        case (r_state)
                            LOAD: begin
                                r_ledCode   <= bus.pat_data;
                                r_ledLit    <= 1'b1;
                                r_spiStatus <= STAT_LED_BASE + {5'b0, bus.pat_data};
                                r_state     <= WAIT_SW;
                            end
                            WAIT_SW: begin
                                if (w_hit) begin
                                    r_state <= HIT;
                                end else if (w_badPress || w_timeoutTc) begin
                                    r_state <= MISS;
                                end
                            end
                            HIT: begin
                                r_score    <= r_score + 5'd1;
                                r_servoPos <= satAdd(r_servoPos, STEP8, MAX8);
                                r_ledLit   <= 1'b0;
                                r_state    <= GAP;
                            end
                            MISS: begin
                                r_ledLit <= 1'b0;
                                r_state  <= GAP;
                            end
                            GAP: begin
                                if (w_gapTc) begin
                                    if (r_round == LAST_ROUND) begin
                                        r_state <= DONE;
                                    end else begin
                                        r_round <= r_round + 4'd1;
                                        r_state <= LOAD;
                                    end
                                end
                            end
                            DONE: begin
                                r_spiStatus <= STAT_DONE_FLAG | {3'b0, r_score};
                                r_busy      <= 1'b0;
                                r_state     <= IDLE;
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.pat_addr   = r_round;
    assign bus.led_code   = r_ledCode;
    assign bus.led_lit    = r_ledLit;
    assign bus.servo_pos  = r_servoPos;
    assign bus.spi_status = r_spiStatus;
    assign bus.score      = r_score;
    assign bus.busy       = r_busy;
    assign bus.maint      = r_maint;

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Sequences one play session of the alien reaction game. Steps through a pattern table of LED targets, lights each target, waits for the matching debounced switch press or a timeout, scores each round, advances the servo, and publishes a status byte for the SPI return path.
- Sits between the SPI command decoder (cmd bytes in), the switch debouncer (press pulses in), and the LED, servo and SPI-out drivers.
- Replaces the inline state block in the top level.

Parameters:
- ROUNDS, 15, number of rounds per game (1..16).
- TIMEOUT_CYC, 50_000_000, cycles allowed per round before a miss (1 s at 50 MHz).
- GAP_CYC, 2_500_000, LED-off cycles between rounds.
- SERVO_STEP, 5, servo increment per hit.
- SERVO_MAX, 89, servo saturation value.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  one-cycle pulse, new SPI byte received
- cmd_byte  in  8  SPI command byte
- sw_valid  in  1  one-cycle pulse, debounced press detected
- sw_code  in  3  index of the pressed switch
- pat_addr  out  4  pattern-table address (= current round)
- pat_data  in  3  LED code read from the table, combinational
- led_code  out  3  target LED index
- led_lit  out  1  target LED enable
- servo_pos  out  8  servo position, 0..SERVO_MAX
- spi_status  out  8  byte returned to MBED
- score  out  5  hits this game
- busy  out  1  game in progress
- maint  out  1  maintenance mode; top level muxes LED/servo/motors from the maintenance path

Behaviour:
- Reset (async, any state): state=IDLE; led_code=0, led_lit=0, servo_pos=0, spi_status=20, score=0, pat_addr=0, busy=0, maint=0. Timers are cleared.
- Commands are acted on only in the cycle where cmd_valid=1. Command values: GO=0x01, MAINT=0x02, ABORT=0x04. Any other byte is ignored.
- IDLE:
  - GO -> LOAD. Same edge: round=0, score=0, servo_pos=0, spi_status=21.
  - MAINT -> MAINT_MODE.
- LOAD (exactly 1 cycle):
  - pat_addr=round; pat_data is sampled at the end of this cycle.
  - Next edge: led_code=pat_data, led_lit=1, spi_status=32+pat_data, timer=0 -> WAIT_SW.
  - Latency from GO pulse to led_lit=1 is 2 edges.
- WAIT_SW: timer increments each cycle.
  - sw_valid and sw_code==led_code -> HIT.
  - sw_valid with a mismatched code -> MISS.
  - timer==TIMEOUT_CYC-1 -> MISS.
  - If a correct press and the timeout occur on the same cycle, the hit wins.
- HIT (1 cycle): score+1; servo_pos=min(servo_pos+SERVO_STEP, SERVO_MAX), computed 9-bit then saturated -> GAP.
- MISS (1 cycle): score and servo unchanged -> GAP.
- GAP: led_lit=0 on entry; wait GAP_CYC cycles.
  - If round==ROUNDS-1 -> DONE.
  - Otherwise round+1 -> LOAD.
  - sw_valid pulses during GAP are ignored.
- DONE (1 cycle): spi_status=0x80|score -> IDLE. The status is held until the next GO.
- ABORT in LOAD/WAIT_SW/HIT/MISS/GAP/DONE -> IDLE next edge: led_lit=0, spi_status=20. Score and servo_pos keep their values.
- GO while a game is running is ignored.
- MAINT_MODE: maint=1; every output except maint holds its value. ABORT -> IDLE with maint=0 and spi_status=20. GO and MAINT are ignored.
- busy=1 in LOAD, WAIT_SW, HIT, MISS, GAP, DONE.
- The round counter is 4-bit and never wraps past ROUNDS-1.
- Widths: timer is 26 bits and saturates only through the state exit. Timer ranges are sized with $clog2 of the parameter.

Decomposition:
- Package game_pkg holds:
  - the state enum: IDLE, LOAD, WAIT_SW, HIT, MISS, GAP, DONE, MAINT_MODE;
  - command constants: CMD_GO=8'h01, CMD_MAINT=8'h02, CMD_ABORT=8'h04;
  - status constants: STAT_IDLE=8'd20, STAT_ACK=8'd21, STAT_LED_BASE=8'd32, STAT_DONE_FLAG=8'h80.
- One sub-module, round_timer: a parameterised clear/enable down-counter with a terminal-count pulse. It is instantiated twice, once for the timeout and once for the gap.

Test Plan:
- Bench setup for all scenarios: ROUNDS=3, TIMEOUT_CYC=100, GAP_CYC=10, table={3,5,1}.
- Reset mid-WAIT_SW (assert rst async between edges) -> outputs go to reset values immediately: led_lit=0, spi_status=20, state IDLE.
- GO, then correct presses at 20 cycles into each round -> led_code 3/5/1, spi_status 35/37/33, servo_pos 5/10/15. Final spi_status=0x83, score=3, busy=0.
- GO, then no presses -> each round times out at 100 cycles. Final spi_status=0x80, servo_pos=0, total game ≈3×(2+100+1+10) cycles.
- Round 1: wrong press sw_code=2 -> MISS. Round 2: correct press on the same cycle as the timeout -> HIT. Round 3: timeout. Final score=1, spi_status=0x81.
- SERVO_STEP=40, all hits -> servo_pos 40, 80, then saturates at 89.
- MAINT in IDLE -> maint=1, GO ignored. ABORT -> maint=0, spi_status=20. ABORT mid-GAP of round 2 -> IDLE, led_lit=0, score retained.
